hex_scan_driver: RTL

Time-multiplexed scan controller for a bank of seven-segment digits. It holds a multi-nibble display value, cycles through digit positions at a programmable refresh rate, and presents one 4-bit nibble at a time to the downstream hex-to-seven-segment decoder. It also drives the matching one-hot digit enable. Frame-coherent value updates, leading-zero blanking and an anti-ghosting dead gap between digits are handled here, so the decoder stays purely combinational.

---
 rtl/hex_scan_driver_pkg.sv | 19 +
 rtl/hex_scan_if.sv | 25 ++
 rtl/hex_scan_driver_timer.sv | 27 ++
 rtl/hex_scan_driver.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/hex_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan controller: scan states,
// nibble width and the digit enable decode.
package hex_scan_driver_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ON,
    ST_GAP
  } scan_state_t;

  // Callers narrow the result to their own digit count with a size cast
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input int unsigned idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/hex_scan_if.sv
// Display-value side and decoder side of the scan controller, bundled for
// the parent that owns both the value source and the segment decoder.
interface hex_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                                                  load;
  logic [hex_scan_driver_pkg::NIBBLE_W*NUM_DIGITS-1:0]   value;
  logic                                                  blank_lz;
  logic [hex_scan_driver_pkg::NIBBLE_W-1:0]              nibble;
  logic [NUM_DIGITS-1:0]                                 digit_sel;
  logic                                                  load_pending;
  logic                                                  frame_start;

  modport master (
    output load, value, blank_lz,
    input  nibble, digit_sel, load_pending, frame_start
  );

  modport slave (
    input  load, value, blank_lz,
    output nibble, digit_sel, load_pending, frame_start
  );

endinterface

// File: rtl/hex_scan_driver_timer.sv
// Loadable down-counter shared by the ON and GAP phases; expire is high on
// the last cycle of a phase that was started with the given terminal count.
module scan_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] terminal,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= terminal - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed digit scanner: holds a frame-coherent display value and
// presents one nibble plus a one-hot digit enable at a time.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input logic       clk,
  input logic       rst_n,
  hex_scan_if.slave bus
);

  localparam int VAL_W     = NIBBLE_W * NUM_DIGITS;
  localparam int MAX_PHASE = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam int IDX_W     = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [VAL_W-1:0] shadow;
  logic [VAL_W-1:0] display;
  logic [VAL_W-1:0] shifted;
  logic             enter_first;
  logic             timer_start;
  logic [CNT_W-1:0] timer_term;
  logic             timer_expire;
  logic             advance;
  logic             wrap;
  logic             blanked;

  scan_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (timer_start),
    .terminal(timer_term),
    .expire  (timer_expire)
  );

  always_comb begin
    timer_start = 1'b0;
    timer_term  = ON_TERM;
    advance     = 1'b0;
    case (state)
      ST_OFF: timer_start = bus.load;
      ST_ON: begin
        if (timer_expire) begin
          timer_start = 1'b1;
          if (DEAD_CYCLES > 0) begin
            timer_term = GAP_TERM;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (timer_expire) begin
          timer_start = 1'b1;
          advance     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign next_idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  assign wrap     = advance && (idx == LAST_IDX);
  assign shifted  = display >> {idx, 2'b00};
  assign blanked  = bus.blank_lz && (idx != '0) && (shifted == '0);

  // Outputs are decoded from the state one edge later, so every output is a
  // flop and the whole scan is shifted uniformly by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_OFF;
      idx              <= '0;
      shadow           <= '0;
      display          <= '0;
      enter_first      <= 1'b0;
      bus.load_pending <= 1'b0;
      bus.nibble       <= '0;
      bus.digit_sel    <= '0;
      bus.frame_start  <= 1'b0;
    end else begin
      enter_first <= 1'b0;
      case (state)
        ST_OFF: begin
          if (bus.load) begin
            state       <= ST_ON;
            idx         <= '0;
            display     <= bus.value;
            enter_first <= 1'b1;
          end
        end
        ST_ON: begin
          if (timer_expire && (DEAD_CYCLES > 0)) begin
            state <= ST_GAP;
          end
        end
        default: ;
      endcase

      if (advance) begin
        state <= ST_ON;
        idx   <= next_idx;
      end

      // The copy reads the old shadow, and a load on this same edge re-arms
      // load_pending below so the newer value waits for the following frame.
      if (wrap) begin
        display          <= shadow;
        bus.load_pending <= 1'b0;
        enter_first      <= 1'b1;
      end

      if (bus.load) begin
        shadow <= bus.value;
        if (state != ST_OFF) begin
          bus.load_pending <= 1'b1;
        end
      end

      bus.frame_start <= enter_first;
      bus.digit_sel   <= '0;
      if (state == ST_ON) begin
        bus.nibble <= shifted[NIBBLE_W-1:0];
        if (!blanked) begin
          bus.digit_sel <= NUM_DIGITS'(digit_onehot(32'(idx)));
        end
      end
    end
  end

endmodule
